// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - fetch-stage next-PC predictor with a trained 2-bit counter table
// Combinational lookup on the fetch PC; the execute stage trains the table through the update port.
module bht_predictor #(
  parameter int IDX_W  = 6,
  parameter int TAG_W  = 16,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       pc,
  input  logic [31:0]       raw_instr,
  output logic [63:0]       predPC,
  output logic              pred_taken,
  output logic              pred_hit,
  input  logic              clear,
  input  logic              upd_valid,
  input  logic [63:0]       upd_pc,
  input  logic [1:0]        upd_kind,
  input  logic              upd_taken,
  input  logic [63:0]       upd_target,
  input  logic              upd_mispred,
  output logic [STAT_W-1:0] stat_upd,
  output logic [STAT_W-1:0] stat_miss
);

  localparam int N = 1 << IDX_W;

  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] K_B    = 2'b00;
  localparam logic [1:0] K_RSVD = 2'b11;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [N-1:0]       r_valid;
  logic [1:0]         r_ctr    [N];
  logic [TAG_W-1:0]   r_tag    [N];
  logic [63:0]        r_target [N];
  logic [STAT_W-1:0]  r_stat_upd;
  logic [STAT_W-1:0]  r_stat_miss;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic [6:0]         w_opcode;
  logic [63:0]        w_bimm;
  logic [63:0]        w_jimm;
  logic [63:0]        w_pc4;
  logic               w_b_taken;

  logic [IDX_W-1:0]   w_upd_idx;
  logic [TAG_W-1:0]   w_upd_tag;
  logic               w_upd_hit;
  logic               w_upd_is_b;
  logic               w_upd_write;
  logic               w_tgt_write;
  logic [1:0]         w_upd_ctr;
  logic [1:0]         w_ctr_next;
  logic               w_unused;

  // ---------------- lookup ----------------
  assign w_idx    = pc[IDX_W+1:2];
  assign w_tag    = pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_opcode = raw_instr[6:0];
  assign w_bimm   = {{51{raw_instr[31]}}, raw_instr[31], raw_instr[7],
                     raw_instr[30:25], raw_instr[11:8], 1'b0};
  assign w_jimm   = {{43{raw_instr[31]}}, raw_instr[31], raw_instr[19:12],
                     raw_instr[20], raw_instr[30:21], 1'b0};
  assign w_pc4    = pc + 64'd4;
  // Without a table entry, fall back to backward-taken / forward-not-taken.
  assign w_b_taken = w_hit ? r_ctr[w_idx][1] : w_bimm[63];

  always_comb begin
    predPC     = w_pc4;
    pred_taken = 1'b0;
    case (w_opcode)
      OP_B: begin
        pred_taken = w_b_taken;
        predPC     = w_b_taken ? (pc + w_bimm) : w_pc4;
      end
      OP_JAL: begin
        pred_taken = 1'b1;
        predPC     = pc + w_jimm;
      end
      OP_JALR: begin
        if (w_hit) begin
          pred_taken = 1'b1;
          predPC     = r_target[w_idx];
        end
      end
      default: begin
        pred_taken = 1'b0;
        predPC     = w_pc4;
      end
    endcase
  end

  assign pred_hit = w_hit;

  // ---------------- training ----------------
  assign w_upd_idx   = upd_pc[IDX_W+1:2];
  assign w_upd_tag   = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_is_b  = (upd_kind == K_B);
  assign w_upd_write = upd_valid && !clear && (upd_kind != K_RSVD);
  assign w_tgt_write = w_upd_write && (!w_upd_is_b || upd_taken);
  assign w_upd_ctr   = r_ctr[w_upd_idx];

  always_comb begin
    w_ctr_next = w_upd_ctr;
    if (!w_upd_is_b) begin
      w_ctr_next = CTR_ST;
    end else if (!w_upd_hit) begin
      w_ctr_next = upd_taken ? CTR_WT : CTR_WNT;
    end else if (upd_taken) begin
      if (w_upd_ctr != CTR_ST) w_ctr_next = w_upd_ctr + 2'd1;
    end else begin
      if (w_upd_ctr != CTR_SNT) w_ctr_next = w_upd_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= '0;
      r_stat_upd  <= '0;
      r_stat_miss <= '0;
      for (int i = 0; i < N; i++) r_ctr[i] <= CTR_WNT;
    end else begin
      if (clear) begin
        r_valid <= '0;
        for (int i = 0; i < N; i++) r_ctr[i] <= CTR_WNT;
      end else if (w_upd_write) begin
        r_valid[w_upd_idx] <= 1'b1;
        r_ctr[w_upd_idx]   <= w_ctr_next;
      end
      if (upd_valid) r_stat_upd <= r_stat_upd + STAT_W'(1);
      if (upd_valid && upd_mispred) r_stat_miss <= r_stat_miss + STAT_W'(1);
    end
  end

  // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_upd_write) r_tag[w_upd_idx] <= w_upd_tag;
    if (w_tgt_write) r_target[w_upd_idx] <= upd_target;
  end

  assign stat_upd  = r_stat_upd;
  assign stat_miss = r_stat_miss;

  assign w_unused = ^{pc[1:0], pc[63:IDX_W+TAG_W+2], upd_pc[1:0], upd_pc[63:IDX_W+TAG_W+2]};

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - scoreboard bench for bht_predictor
// Expected predictions are queued as each lookup is driven and compared when sampled.
module tb_bht_predictor;

  logic        clk;
  logic        reset;
  logic [63:0] pc;
  logic [31:0] raw_instr;
  logic [63:0] predPC;
  logic        pred_taken;
  logic        pred_hit;
  logic        clear;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic [1:0]  upd_kind;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic        upd_mispred;
  logic [31:0] stat_upd;
  logic [31:0] stat_miss;

  bht_predictor dut (
    .clk(clk), .reset(reset), .pc(pc), .raw_instr(raw_instr),
    .predPC(predPC), .pred_taken(pred_taken), .pred_hit(pred_hit),
    .clear(clear), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_kind(upd_kind),
    .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispred(upd_mispred),
    .stat_upd(stat_upd), .stat_miss(stat_miss)
  );

  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic        taken;
    logic        hit;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_upd = 0;
  int   exp_miss = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JALR = 32'h0000_80E7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic step_lookup(input string tag, input logic [63:0] p, input logic [31:0] ins,
                             input logic [63:0] epc, input logic et, input logic eh);
    exp_t e;
    pc        = p;
    raw_instr = ins;
    e.tag = tag; e.pc = epc; e.taken = et; e.hit = eh;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".pc"},    predPC,     e.pc);
    check({e.tag, ".taken"}, pred_taken, {63'd0, e.taken});
    check({e.tag, ".hit"},   pred_hit,   {63'd0, e.hit});
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic [63:0] p, input logic [1:0] k, input logic t,
                         input logic [63:0] tgt, input logic mp);
    upd_valid = 1'b1; upd_pc = p; upd_kind = k; upd_taken = t;
    upd_target = tgt; upd_mispred = mp;
  endtask

  task automatic do_upd(input logic [63:0] p, input logic [1:0] k, input logic t,
                        input logic [63:0] tgt, input logic mp);
    set_upd(p, k, t, tgt, mp);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    exp_upd++;
    if (mp) exp_miss++;
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".stat_upd"},  {32'd0, stat_upd},  64'(exp_upd));
    check({tag, ".stat_miss"}, {32'd0, stat_miss}, 64'(exp_miss));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_kind = 2'b00;
    upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
    pc = 64'h1000; raw_instr = NOP;
    #1;
    step_lookup("rst_nop", 64'h1000, NOP, 64'h1004, 1'b0, 1'b0);
    check_stats("rst");
    reset = 1'b0;

    step_lookup("btfn_back", 64'h8000_0000, enc_b(-13'sd8), 64'h7FFF_FFF8, 1'b1, 1'b0);
    step_lookup("btfn_fwd", 64'h8000_0000, enc_b(13'sd16), 64'h8000_0004, 1'b0, 1'b0);
    step_lookup("wrap_nop", 64'hFFFF_FFFF_FFFF_FFFC, NOP, 64'h0, 1'b0, 1'b0);
    step_lookup("wrap_back", 64'h4, enc_b(-13'sd8), 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0);

    do_upd(64'h8000_0010, 2'b00, 1'b1, 64'h8000_0020, 1'b1);
    step_lookup("train1", 64'h8000_0010, enc_b(13'sd16), 64'h8000_0020, 1'b1, 1'b1);
    check_stats("train1");

    for (int i = 0; i < 4; i++) do_upd(64'h8000_0010, 2'b00, 1'b1, 64'h8000_0020, 1'b0);
    do_upd(64'h8000_0010, 2'b00, 1'b0, 64'hDEAD_0000, 1'b1);
    step_lookup("sat_hi_nt1", 64'h8000_0010, enc_b(13'sd16), 64'h8000_0020, 1'b1, 1'b1);
    do_upd(64'h8000_0010, 2'b00, 1'b0, 64'hDEAD_0000, 1'b0);
    step_lookup("nt2", 64'h8000_0010, enc_b(13'sd16), 64'h8000_0014, 1'b0, 1'b1);
    do_upd(64'h8000_0010, 2'b00, 1'b0, 64'hDEAD_0000, 1'b0);
    do_upd(64'h8000_0010, 2'b00, 1'b0, 64'hDEAD_0000, 1'b0);
    do_upd(64'h8000_0010, 2'b00, 1'b1, 64'h8000_0020, 1'b0);
    step_lookup("sat_lo_t1", 64'h8000_0010, enc_b(13'sd16), 64'h8000_0014, 1'b0, 1'b1);
    do_upd(64'h8000_0010, 2'b00, 1'b0, 64'hDEAD_0000, 1'b0);
    step_lookup("tgt_keep", 64'h8000_0010, JALR, 64'h8000_0020, 1'b1, 1'b1);
    do_upd(64'h8000_0010, 2'b00, 1'b1, 64'h8000_0020, 1'b0);
    do_upd(64'h8000_0010, 2'b00, 1'b1, 64'h8000_0020, 1'b0);
    step_lookup("retrain", 64'h8000_0010, enc_b(13'sd16), 64'h8000_0020, 1'b1, 1'b1);
    check_stats("sat");

    do_upd(64'h8000_0100, 2'b10, 1'b1, 64'h8000_2000, 1'b1);
    step_lookup("jalr_hit", 64'h8000_0100, JALR, 64'h8000_2000, 1'b1, 1'b1);
    step_lookup("jalr_alias", 64'h8001_0100, JALR, 64'h8001_0104, 1'b0, 1'b0);
    step_lookup("jalr_miss", 64'h8000_0200, JALR, 64'h8000_0204, 1'b0, 1'b0);
    step_lookup("nop_hit", 64'h8000_0100, NOP, 64'h8000_0104, 1'b0, 1'b1);

    do_upd(64'h8000_0080, 2'b11, 1'b1, 64'h8000_3000, 1'b0);
    step_lookup("rsvd_kind", 64'h8000_0080, JALR, 64'h8000_0084, 1'b0, 1'b0);
    check_stats("rsvd");

    set_upd(64'h8000_0040, 2'b00, 1'b1, 64'h8000_0060, 1'b0);
    step_lookup("same_old", 64'h8000_0040, enc_b(13'sd32), 64'h8000_0044, 1'b0, 1'b0);
    upd_valid = 1'b0;
    exp_upd++;
    step_lookup("same_new", 64'h8000_0040, enc_b(13'sd32), 64'h8000_0060, 1'b1, 1'b1);

    set_upd(64'h8000_0300, 2'b01, 1'b1, 64'h9000_0000, 1'b1);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0; upd_valid = 1'b0;
    exp_upd++; exp_miss++;
    check_stats("clear");
    step_lookup("clr_upd", 64'h8000_0300, JALR, 64'h8000_0304, 1'b0, 1'b0);
    step_lookup("clr_jalr", 64'h8000_0100, JALR, 64'h8000_0104, 1'b0, 1'b0);
    step_lookup("clr_b", 64'h8000_0010, enc_b(13'sd16), 64'h8000_0014, 1'b0, 1'b0);

    do_upd(64'h8000_0100, 2'b10, 1'b1, 64'h8000_4000, 1'b0);
    step_lookup("pre_rst", 64'h8000_0100, JALR, 64'h8000_4000, 1'b1, 1'b1);
    set_upd(64'h8000_0200, 2'b01, 1'b1, 64'h8000_5000, 1'b1);
    pc = 64'h8000_0100; raw_instr = JALR;
    #3;
    reset = 1'b1;
    #1;
    exp_upd = 0; exp_miss = 0;
    check("async.hit", {63'd0, pred_hit}, 64'd0);
    check("async.pc", predPC, 64'h8000_0104);
    check_stats("async");
    upd_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step_lookup("post_rst_upd", 64'h8000_0200, JALR, 64'h8000_0204, 1'b0, 1'b0);
    step_lookup("post_rst_jal", 64'h8000_0000, enc_j(21'h800), 64'h8000_0800, 1'b1, 1'b0);
    check_stats("end");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
